// File: rtl/tag_compare_stage_if.sv
// Lookup request, tag-array read and result-slot signals of the tag compare stage.
// The stage uses the slave view; the requester / tag array side uses the master view.
interface tag_compare_stage_if #(
  parameter int TAG_W = 8,
  parameter int IDX_W = 4,
  parameter int WAYS  = 4
);
  localparam int WAY_W = $clog2(WAYS);

  logic                    req_valid;
  logic                    req_ready;
  logic [TAG_W-1:0]        req_tag;
  logic [IDX_W-1:0]        req_index;
  logic                    tag_rd_en;
  logic [IDX_W-1:0]        tag_rd_idx;
  logic [WAYS*TAG_W-1:0]   tag_rd_tags;
  logic [WAYS-1:0]         tag_rd_valid;
  logic                    res_valid;
  logic                    res_ready;
  logic                    res_hit;
  logic [WAYS-1:0]         res_way_oh;
  logic [WAY_W-1:0]        res_way_idx;
  logic                    res_multi_hit;
  logic [TAG_W-1:0]        res_tag;
  logic [IDX_W-1:0]        res_index;

  modport slave (
    input  req_valid, req_tag, req_index, tag_rd_tags, tag_rd_valid, res_ready,
    output req_ready, tag_rd_en, tag_rd_idx, res_valid, res_hit, res_way_oh,
           res_way_idx, res_multi_hit, res_tag, res_index
  );

  modport master (
    output req_valid, req_tag, req_index, tag_rd_tags, tag_rd_valid, res_ready,
    input  req_ready, tag_rd_en, tag_rd_idx, res_valid, res_hit, res_way_oh,
           res_way_idx, res_multi_hit, res_tag, res_index
  );
endinterface

// File: rtl/tag_compare_stage.sv
// Hit-detection stage of the cache lookup path: reads the tag array, compares every way
// against the request tag and holds hit / way information in a valid/ready result slot.
module and_wordgate #(
  parameter int w = 9
) (
  input  logic [w-1:0] din,
  output logic         dout
);
  assign dout = &din;
endmodule

// state | meaning
// IDLE  | ready for a request; accepting one fires the tag array read
// READ  | tag array data valid, per-way compare, result registered
// RESP  | result held until the consumer takes it
module tag_compare_stage #(
  parameter int TAG_W = 8,
  parameter int IDX_W = 4,
  parameter int WAYS  = 4
) (
  input logic             clk,
  input logic             rst,
  tag_compare_stage_if.slave bus
);
  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, RESP = 2'd2} state_t;

  state_t           state, state_next;
  logic             accept;
  logic [TAG_W-1:0] tag_q;
  logic [IDX_W-1:0] idx_q;
  logic [WAYS-1:0]  match;
  logic [WAYS-1:0]  way_oh_d;
  logic [WAY_W-1:0] way_idx_d;
  logic             multi_d;

  logic             hit_q;
  logic [WAYS-1:0]  way_oh_q;
  logic [WAY_W-1:0] way_idx_q;
  logic             multi_q;
  logic [TAG_W-1:0] res_tag_q;
  logic [IDX_W-1:0] res_index_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.req_valid) state_next = READ;
      READ:    state_next = RESP;
      RESP:    if (bus.res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept         = (state == IDLE) && bus.req_valid;
    bus.req_ready  = (state == IDLE);
    bus.res_valid  = (state == RESP);
    bus.tag_rd_en  = accept;
    bus.tag_rd_idx = accept ? bus.req_index : idx_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q <= '0;
      idx_q <= '0;
    end else if (accept) begin
      tag_q <= bus.req_tag;
      idx_q <= bus.req_index;
    end
  end

  // {valid, bitwise XNOR} per way; a cleared valid bit forces a miss for that way
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [TAG_W:0] match_vec;
    assign match_vec = {bus.tag_rd_valid[w], ~(bus.tag_rd_tags[w*TAG_W +: TAG_W] ^ tag_q)};
    and_wordgate #(.w(TAG_W+1)) u_gate (.din(match_vec), .dout(match[w]));
  end

  // Descending scan so the lowest-numbered matching way wins
  always_comb begin
    way_oh_d  = '0;
    way_idx_d = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (match[w]) begin
        way_oh_d    = '0;
        way_oh_d[w] = 1'b1;
        way_idx_d   = WAY_W'(w);
      end
    end
    multi_d = (match & (match - WAYS'(1))) != '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q       <= 1'b0;
      way_oh_q    <= '0;
      way_idx_q   <= '0;
      multi_q     <= 1'b0;
      res_tag_q   <= '0;
      res_index_q <= '0;
    end else if (state == READ) begin
      hit_q       <= |match;
      way_oh_q    <= way_oh_d;
      way_idx_q   <= way_idx_d;
      multi_q     <= multi_d;
      res_tag_q   <= tag_q;
      res_index_q <= idx_q;
    end
  end

  assign bus.res_hit       = hit_q;
  assign bus.res_way_oh    = way_oh_q;
  assign bus.res_way_idx   = way_idx_q;
  assign bus.res_multi_hit = multi_q;
  assign bus.res_tag       = res_tag_q;
  assign bus.res_index     = res_index_q;
endmodule
